// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the operation encodings driven on the op port, the FSM state
// encodings and the fixed issue-to-done latency.
package mul_div_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_MULT  = 2'b01,
        MD_DIVU  = 2'b10,
        MD_DIV   = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIN  = 2'b10
    } md_state_e;

    // Cycles from the accepting edge to the done pulse, identical for all ops.
    localparam int MD_LATENCY = 33;

endpackage

// File: rtl/mul_div_unit_sign_fix.sv
// md_sign_fix: combinational conditional two's-complement negation.
// Used both to take magnitudes of signed operands on entry and to apply
// result signs to the product, quotient and remainder on completion.
//   val : input value
//   neg : 1 = return -val, 0 = pass val through
//   res : result, same width as val
module md_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    // The magnitude of the most negative value wraps to itself, which is
    // exactly the correct unsigned magnitude (e.g. 0x80000000).
    assign res = neg ? ({W{1'b0}} - val) : val;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start, op, a, b     : issue request, operation select, rs/rt operands
//   hi_we, lo_we, wdata : MTHI/MTLO writes (honoured only when idle, no start)
//   busy, done          : operation in flight, one-cycle completion pulse
//   div_zero            : sticky flag, last completed divide had b == 0
//   hi, lo              : architectural HI/LO registers
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e            state, state_next;
    logic [CNT_W-1:0]     cnt;
    md_op_e               op_q;
    logic [WIDTH-1:0]     mcand;   // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   acc;     // mul: {partial, multiplier}; div: {rem, quo}
    logic [WIDTH-1:0]     a_raw;
    logic                 b_zero;
    logic                 sign_p, sign_q, sign_r;

    logic                 op_signed, op_div, op_q_div;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_sh, div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_res;
    logic [WIDTH-1:0]     quo_res, rem_res;

    assign op_signed = (op == MD_MULT) || (op == MD_DIV);
    assign op_div    = (op == MD_DIVU) || (op == MD_DIV);
    assign op_q_div  = (op_q == MD_DIVU) || (op_q == MD_DIV);

    md_sign_fix #(.W(WIDTH)) u_abs_a (
        .val(a), .neg(op_signed & a[WIDTH-1]), .res(mag_a)
    );
    md_sign_fix #(.W(WIDTH)) u_abs_b (
        .val(b), .neg(op_signed & b[WIDTH-1]), .res(mag_b)
    );
    md_sign_fix #(.W(2*WIDTH)) u_fix_prod (
        .val(acc), .neg(sign_p), .res(prod_res)
    );
    md_sign_fix #(.W(WIDTH)) u_fix_quo (
        .val(acc[WIDTH-1:0]), .neg(sign_q), .res(quo_res)
    );
    md_sign_fix #(.W(WIDTH)) u_fix_rem (
        .val(acc[2*WIDTH-1:WIDTH]), .neg(sign_r), .res(rem_res)
    );

    // Shift-add: add multiplicand to the upper half when the current
    // multiplier bit is set, then shift the whole register right by one.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                    + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder and
    // keep the subtraction only if it did not go negative.
    assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff = rem_sh - {1'b0, mcand};
    assign div_next = div_diff[WIDTH]
                    ? {rem_sh[WIDTH-1:0],   acc[WIDTH-2:0], 1'b0}
                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_next = S_CALC;
            end
            S_CALC: if (cnt == CNT_W'(WIDTH - 1)) state_next = S_FIN;
            S_FIN:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Control and architectural registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= (state == S_FIN);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt <= '0;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                S_CALC: cnt <= cnt + 1'b1;
                S_FIN: begin
                    if (op_q_div) begin
                        if (b_zero) begin
                            lo <= {WIDTH{1'b1}};
                            hi <= a_raw;
                        end else begin
                            lo <= quo_res;
                            hi <= rem_res;
                        end
                        div_zero <= b_zero;
                    end else begin
                        {hi, lo} <= prod_res;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand latches and iteration datapath.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            op_q   <= md_op_e'(op);
            acc    <= {{WIDTH{1'b0}}, mag_a};
            mcand  <= mag_b;
            a_raw  <= a;
            b_zero <= (b == '0);
            sign_p <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            sign_q <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            sign_r <= op_signed & a[WIDTH-1] & op_div;
        end else if (state == S_CALC) begin
            acc <= op_q_div ? div_next : mul_next;
        end
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative 32-bit multiply/divide unit for the EX stage of the pipelined CPU.
- Executes MULT, MULTU, DIV and DIVU alongside the single-cycle ALU, using a start/busy/done handshake.
- Results go to architectural HI/LO registers, which MFHI/MFLO read and MTHI/MTLO write.
- The hazard unit uses busy to stall MFHI/MFLO and any new mul/div issue.

Parameters:
- WIDTH, 32: operand and HI/LO width.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  issue request; accepted only while not busy.
- op  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  input  WIDTH  rs operand (multiplicand or dividend).
- b  input  WIDTH  rt operand (multiplier or divisor).
- hi_we  input  1  MTHI write strobe.
- lo_we  input  1  MTLO write strobe.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in flight.
- done  output  1  one-cycle completion pulse.
- div_zero  output  1  sticky flag: last divide had b==0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0. Reset mid-operation aborts the operation; no partial result reaches hi/lo.
- State machine: IDLE -> CALC -> FIN -> IDLE.
- IDLE:
  - start=1 at edge E0 latches op, a and b. For signed ops it latches |a| and |b| and records the result signs.
  - For MULT: sign_p = a[31]^b[31].
  - For DIV: sign_q = a[31]^b[31], sign_r = a[31].
  - Clears the counter and enters CALC. busy=1 from E0.
- CALC: one radix-2 iteration per edge, exactly WIDTH iterations (E1..E32). Then enter FIN.
  - Multiply: shift-add into a 2*WIDTH product register.
  - Divide: restoring shift-subtract, giving remainder and quotient.
- FIN: at edge E33 write the sign-corrected result, pulse done=1 for one cycle, set busy=0, return to IDLE.
  - Multiply: hi = product[63:32], lo = product[31:0].
  - Divide: lo = quotient, hi = remainder.
- Latency: fixed 33 cycles from acceptance to done, for every op and operand value.
- Signed divide semantics: quotient truncates toward zero; remainder takes the sign of the dividend.
- Widths and overflow:
  - |−2^31| is 0x80000000, handled as a 32-bit unsigned magnitude.
  - Multiply negation is two's complement over the 64-bit product.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; no trap.
- Divide by zero (b==0, DIVU or DIV):
  - Same 33-cycle latency.
  - Result: lo=0xFFFFFFFF, hi=a (original, unsigned view), div_zero=1.
  - div_zero clears when any later divide completes with b!=0. Multiplies leave it unchanged.
- start while busy: ignored, with no queueing. The issuing stage is stalled by busy.
- start during the done cycle: accepted, because state is IDLE. busy returns to 1 next cycle, and hi/lo keep the finished values until the next FIN.
- hi_we/lo_we:
  - Write on the edge when state==IDLE and start==0; both may write in the same cycle.
  - Ignored while busy.
  - If asserted in the same cycle as an accepted start, start wins and the write is dropped.
- hi/lo change only at FIN, on an MT write, or on reset.

Decomposition:
- Shared package holds:
  - op encodings MD_MULTU=2'b00, MD_MULT=2'b01, MD_DIVU=2'b10, MD_DIV=2'b11;
  - state encodings S_IDLE, S_CALC, S_FIN;
  - MD_LATENCY=33.
- One natural sub-module: md_sign_fix, a combinational magnitude/negate helper used on entry (abs) and in FIN (conditional negation of product, quotient and remainder).
- The datapath and FSM stay in mul_div_unit.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done exactly 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
- MULT a=0xFFFFFFFD (−3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then DIV a=0xFFFFFFF9 (−7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100, div_zero=1; then DIVU a=100, b=7 -> lo=14, hi=2, div_zero=0.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; then start asserted in the done cycle is accepted; start at cycle 5 of busy is ignored (no extra done pulse).
- hi_we with wdata=0x1234 while idle -> hi=0x1234; lo_we while busy -> lo unchanged; hi_we together with start -> write dropped.
- reset asserted at cycle 10 of a MULTU -> next cycle busy=0, done=0, hi=lo=0; no done pulse follows.
